fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0080, exception redirect address; used only with FETCH_SEQ_EXC_EN.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  1  decode cannot accept an instruction this cycle.
REQ-006 jump_i, jump_target_i  input  1, 32  unconditional redirect and its target.
REQ-007 branch_i, branch_target_i  input  1, 32  taken-branch redirect and its target.
REQ-008 exc_i  input  1  exception redirect; present only with FETCH_SEQ_EXC_EN.
REQ-009 mem_req_o, mem_addr_o  output  1, 32  instruction memory request and word address.
REQ-010 mem_ready_i, mem_rdata_i  input  1, 32  memory response strobe and instruction word.
REQ-011 valid_o, instr_o, pc_o  output  1, 32, 32  fetched instruction to decode and its address.

Function
REQ-012 States: BOOT, REQ, HOLD; the encoding is free.
REQ-013 BOOT: entered on reset; lasts exactly one cycle; mem_req_o=0; next state is REQ with pc=RESET_PC.
REQ-014 REQ: mem_req_o=1 and mem_addr_o=pc; mem_addr_o is stable until mem_ready_i or a redirect.
REQ-015 REQ with mem_ready_i=1 and no redirect:
- instr_o<=mem_rdata_i, pc_o<=pc, valid_o<=1 (latency is 1 cycle from the ready strobe).
- If stall_i=0: pc<=pc+4 and the state stays REQ.
- If stall_i=1: the next state is HOLD and pc is unchanged.
REQ-016 REQ with mem_ready_i=0 and no redirect: valid_o<=0 and pc is unchanged.
REQ-017 HOLD: mem_req_o=0 and valid_o, instr_o, pc_o are held; when stall_i drops, pc<=pc+4, valid_o<=0 and the next state is REQ.
REQ-018 Redirect priority: exc_i > jump_i > branch_i > sequential.
REQ-019 A redirect in any non-BOOT state:
- pc<=selected target with bits [1:0] forced to 0.
- valid_o<=0 and the next state is REQ.
- A mem_ready_i response in the same cycle is discarded.
REQ-020 A redirect overrides stall_i.
REQ-021 A redirect while in BOOT is ignored.
REQ-022 pc+4 wraps modulo 2^32: 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-023 mem_addr_o[1:0] is always 2'b00.

Reset
REQ-024 Asserting reset at any time, including mid-request, forces BOOT immediately.
REQ-025 Reset values: pc=RESET_PC, mem_req_o=0, mem_addr_o=RESET_PC, valid_o=0, instr_o=0, pc_o=0.
REQ-026 An in-flight memory response arriving during or after reset is ignored until the first REQ cycle.

Configuration
REQ-027 Macro FETCH_SEQ_EXC_EN.
- Defined: the exc_i port exists, has top redirect priority and redirects to EXC_VECTOR.
- Undefined: the exc_i port and all exception logic are absent; priority is jump_i > branch_i.

Verification
REQ-028 Release reset, memory ready every cycle, no stall -> mem_addr_o sequence 0,4,8,C; valid_o high from the 3rd cycle; pc_o sequence 0,4,8.
REQ-029 mem_ready_i held low for 3 cycles at pc=0x10 -> mem_addr_o stays 0x10 and valid_o stays 0; on ready, instr_o=mem_rdata_i and pc_o=0x10.
REQ-030 stall_i high for 2 cycles after fetching 0x8 -> valid_o=1, pc_o=0x8 held; mem_req_o=0; after release, next fetch is at 0xC.
REQ-031 jump_i and branch_i together (targets 0x100, 0x200) while mem_ready_i=1 -> response discarded; next mem_addr_o=0x100; branch target 0x203 -> fetch at 0x200.
REQ-032 Fetch at 32'hFFFF_FFFC -> next mem_addr_o=0; reset pulsed low mid-REQ -> outputs at reset values and next fetch at RESET_PC.
REQ-033 With FETCH_SEQ_EXC_EN defined and exc_i, jump_i asserted together -> next mem_addr_o=0x80.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: BOOT/REQ/HOLD instruction fetch sequencer.
// Define FETCH_SEQ_EXC_EN to add the exc_i redirect to EXC_VECTOR.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
`ifdef FETCH_SEQ_EXC_EN
  ,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
`ifdef FETCH_SEQ_EXC_EN
  input  logic        exc_i,
`endif
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam logic [31:0] BOOT_PC =
    RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redir;
  logic [31:0] redir_tgt;
  logic [31:0] redir_pc;
  logic [31:0] pc_inc;

  assign mem_addr_o = pc;
  assign pc_inc     = pc + 32'd4;
  assign redir_pc   = redir_tgt & 32'hFFFF_FFFC;

  // Pick the highest-priority redirect and its target.
  always_comb begin
    redir     = 1'b0;
    redir_tgt = pc;
    priority case (1'b1)
`ifdef FETCH_SEQ_EXC_EN
      exc_i: begin
        redir     = 1'b1;
        redir_tgt = EXC_VECTOR;
      end
`endif
      jump_i: begin
        redir     = 1'b1;
        redir_tgt = jump_target_i;
      end
      branch_i: begin
        redir     = 1'b1;
        redir_tgt = branch_target_i;
      end
      default: begin
        redir     = 1'b0;
        redir_tgt = pc;
      end
    endcase
  end

  // Fetch FSM with registered request and decode outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_BOOT;
      pc        <= BOOT_PC;
      mem_req_o <= 1'b0;
      valid_o   <= 1'b0;
      instr_o   <= 32'd0;
      pc_o      <= 32'd0;
    end else begin
      unique case (state)
        S_BOOT: begin
          state     <= S_REQ;
          pc        <= BOOT_PC;
          mem_req_o <= 1'b1;
        end
        S_REQ: begin
          if (redir) begin
            pc      <= redir_pc;
            valid_o <= 1'b0;
          end else if (mem_ready_i) begin
            instr_o <= mem_rdata_i;
            pc_o    <= pc;
            valid_o <= 1'b1;
            if (stall_i) begin
              state     <= S_HOLD;
              mem_req_o <= 1'b0;
            end else begin
              pc <= pc_inc;
            end
          end else begin
            valid_o <= 1'b0;
          end
        end
        S_HOLD: begin
          if (redir) begin
            pc        <= redir_pc;
            valid_o   <= 1'b0;
            state     <= S_REQ;
            mem_req_o <= 1'b1;
          end else if (!stall_i) begin
            pc        <= pc_inc;
            valid_o   <= 1'b0;
            state     <= S_REQ;
            mem_req_o <= 1'b1;
          end
        end
        default: begin
          state     <= S_BOOT;
          mem_req_o <= 1'b0;
          valid_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus with a fetch scoreboard.
// Define FETCH_SEQ_EXC_EN to also exercise the exception redirect.
module tb_fetch_sequencer;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = 32'd0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
`ifdef FETCH_SEQ_EXC_EN
  logic        exc_i = 1'b0;
`endif
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory returns a word derived from the address.
  assign mem_rdata_i = mem_addr_o ^ KEY;

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
`ifdef FETCH_SEQ_EXC_EN
    .exc_i           (exc_i),
`endif
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_rdata_i     (mem_rdata_i),
    .valid_o         (valid_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o)
  );

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic st(
    input string       name,
    input logic        req,
    input logic [31:0] addr,
    input logic        vld
  );
    check({name, ".req"}, {31'd0, mem_req_o},
          {31'd0, req});
    check({name, ".addr"}, mem_addr_o, addr);
    check({name, ".valid"}, {31'd0, valid_o},
          {31'd0, vld});
  endtask

  task automatic push(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = p ^ KEY;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each newly presented instruction pops one entry.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = 32'd0;
  logic [31:0] prev_instr = 32'd0;

  always @(negedge clk) begin
    if (valid_o && (!prev_valid || pc_o != prev_pc ||
                    instr_o != prev_instr)) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h, none expected",
                 pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb.pc", pc_o, e.pc);
        check("sb.instr", instr_o, e.instr);
      end
    end
    prev_valid = valid_o;
    prev_pc    = pc_o;
    prev_instr = instr_o;
  end

  initial begin
    tick();
    tick();
    st("rst", 1'b0, 32'h0, 1'b0);
    check("rst.instr", instr_o, 32'h0);
    check("rst.pc_o", pc_o, 32'h0);

    mem_ready_i = 1'b1;
    reset = 1'b1;
    check("boot.req", {31'd0, mem_req_o}, 32'd0);
    tick();
    st("seq0", 1'b1, 32'h0, 1'b0);
    push(32'h0);
    tick();
    st("seq4", 1'b1, 32'h4, 1'b1);
    push(32'h4);
    tick();
    st("seq8", 1'b1, 32'h8, 1'b1);
    stall_i = 1'b1;
    push(32'h8);
    tick();
    st("hold1", 1'b0, 32'h8, 1'b1);
    check("hold1.pc_o", pc_o, 32'h8);
    tick();
    st("hold2", 1'b0, 32'h8, 1'b1);
    check("hold2.pc_o", pc_o, 32'h8);
    stall_i = 1'b0;
    tick();
    st("unstall", 1'b1, 32'hC, 1'b0);
    push(32'hC);
    tick();
    st("seq10", 1'b1, 32'h10, 1'b1);
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      st("wait10", 1'b1, 32'h10, 1'b0);
    end
    mem_ready_i = 1'b1;
    push(32'h10);
    tick();
    st("seq14", 1'b1, 32'h14, 1'b1);

    jump_i = 1'b1;
    jump_target_i = 32'h100;
    branch_i = 1'b1;
    branch_target_i = 32'h200;
    tick();
    st("jmp_pri", 1'b1, 32'h100, 1'b0);
    jump_i = 1'b0;
    branch_target_i = 32'h203;
    mem_ready_i = 1'b0;
    tick();
    st("br_align", 1'b1, 32'h200, 1'b0);
    branch_i = 1'b0;
    mem_ready_i = 1'b1;
    stall_i = 1'b1;
    push(32'h200);
    tick();
    st("hold200", 1'b0, 32'h200, 1'b1);
    jump_i = 1'b1;
    jump_target_i = 32'h300;
    tick();
    st("jmp_stall", 1'b1, 32'h300, 1'b0);

    stall_i = 1'b0;
    mem_ready_i = 1'b0;
    jump_target_i = 32'hFFFF_FFFC;
    tick();
    st("jmp_top", 1'b1, 32'hFFFF_FFFC, 1'b0);
    jump_i = 1'b0;
    mem_ready_i = 1'b1;
    push(32'hFFFF_FFFC);
    tick();
    st("wrap", 1'b1, 32'h0, 1'b1);
    mem_ready_i = 1'b0;
    tick();
    st("wrap_idle", 1'b1, 32'h0, 1'b0);

    mem_ready_i = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    st("arst", 1'b0, 32'h0, 1'b0);
    check("arst.instr", instr_o, 32'h0);
    check("arst.pc_o", pc_o, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    jump_i = 1'b1;
    jump_target_i = 32'h500;
    st("boot2", 1'b0, 32'h0, 1'b0);
    tick();
    jump_i = 1'b0;
    st("boot_ign", 1'b1, 32'h0, 1'b0);
    push(32'h0);
    tick();
    st("refetch", 1'b1, 32'h4, 1'b1);
    mem_ready_i = 1'b0;
    tick();

`ifdef FETCH_SEQ_EXC_EN
    exc_i = 1'b1;
    jump_i = 1'b1;
    jump_target_i = 32'h100;
    tick();
    st("exc_pri", 1'b1, 32'h80, 1'b0);
    exc_i = 1'b0;
    jump_i = 1'b0;
    tick();
`endif

    tick();
    check("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
